// File: rtl/banff_exec_pkg.sv
// Shared Execute-stage definitions: addressing-mode encodings and sequencer state type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`timescale 1ns/1ps
package banff_exec_pkg;

  // Addressing modes carried on the 2-bit mode field.
  localparam logic [1:0] MODE_BASE_OFS = 2'b00;
  localparam logic [1:0] MODE_POST_INC = 2'b01;
  localparam logic [1:0] MODE_PRE_DEC  = 2'b10;
  localparam logic [1:0] MODE_RSVD     = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } seq_state_t;

endpackage

// File: rtl/mem_addr_calc.sv
// Base-source select plus signed offset add/subtract; yields first beat address and writeback value.
// Latency: purely combinational.
// Backpressure: none (no handshake at this level).
// Ports: i_src_addr packed sources, i_src_sel index (out-of-range -> source 0), i_offset,
//        i_mode; o_first_addr, o_wb_addr, o_wb_en (writeback wanted for this mode).
`timescale 1ns/1ps
module mem_addr_calc
  import banff_exec_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SRC    = 4,
  parameter int SEL_W      = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC*ADDR_WIDTH-1:0] i_src_addr,
  input  logic [SEL_W-1:0]              i_src_sel,
  input  logic [ADDR_WIDTH-1:0]         i_offset,
  input  logic [1:0]                    i_mode,
  output logic [ADDR_WIDTH-1:0]         o_first_addr,
  output logic [ADDR_WIDTH-1:0]         o_wb_addr,
  output logic                          o_wb_en
);

  logic [ADDR_WIDTH-1:0] w_base;
  logic [ADDR_WIDTH-1:0] w_sum;
  logic [ADDR_WIDTH-1:0] w_diff;

  // Source 0 is the fallback, so an index past NUM_SRC lands there.
  always_comb begin
    w_base = i_src_addr[ADDR_WIDTH-1:0];
    for (int i = 1; i < NUM_SRC; i++) begin
      if (i_src_sel == SEL_W'(i)) w_base = i_src_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Two's-complement wrap is intentional: modulo 2^ADDR_WIDTH arithmetic.
  assign w_sum  = w_base + i_offset;
  assign w_diff = w_base - i_offset;

  always_comb begin
    o_first_addr = w_sum;
    o_wb_addr    = w_sum;
    o_wb_en      = 1'b0;
    case (i_mode)
      MODE_POST_INC: begin
        o_first_addr = w_base;
        o_wb_addr    = w_sum;
        o_wb_en      = 1'b1;
      end
      MODE_PRE_DEC: begin
        o_first_addr = w_diff;
        o_wb_addr    = w_diff;
        o_wb_en      = 1'b1;
      end
      default: ; // BASE_OFS and reserved: base+offset, no writeback
    endcase
  end

endmodule

// File: rtl/mem_addr_seq_mux.sv
// Memory-address select/sequencer: picks a base, applies mode/offset, issues N word addresses.
// Latency: 1 cycle accept-to-out_valid; 1 beat/cycle; next command accepted on last-beat handshake.
// Backpressure: out_ready low holds out_addr/out_beat/out_last; in_ready low until the last beat drains.
// Ports: clock/reset (async active-low); in_valid/in_ready command handshake with src_addr,
//        src_sel, offset, mode, beats; out_valid/out_ready beat handshake with out_addr, out_last,
//        out_beat, out_misaligned; wb_valid/wb_addr one-cycle base writeback.
// Option: define MEM_ADDR_ALIGN_CHECK_EN to register an alignment flag per beat (else tied 0).
`timescale 1ns/1ps
module mem_addr_seq_mux
  import banff_exec_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SRC    = 4,
  parameter int MAX_BEATS  = 8,
  parameter int WORD_BYTES = 4,
  parameter int SEL_W      = $clog2(NUM_SRC),
  parameter int BEATS_W    = $clog2(MAX_BEATS + 1),
  parameter int BEAT_IDX_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_SRC*ADDR_WIDTH-1:0] src_addr,
  input  logic [SEL_W-1:0]              src_sel,
  input  logic [ADDR_WIDTH-1:0]         offset,
  input  logic [1:0]                    mode,
  input  logic [BEATS_W-1:0]            beats,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ADDR_WIDTH-1:0]         out_addr,
  output logic                          out_last,
  output logic [BEAT_IDX_W-1:0]         out_beat,
  output logic                          wb_valid,
  output logic [ADDR_WIDTH-1:0]         wb_addr,
  output logic                          out_misaligned
);

  seq_state_t              r_state;
  logic                    r_out_valid;
  logic [ADDR_WIDTH-1:0]   r_out_addr;
  logic [BEAT_IDX_W-1:0]   r_out_beat;
  logic [BEAT_IDX_W-1:0]   r_last_idx;
  logic                    r_out_last;
  logic                    r_wb_valid;
  logic [ADDR_WIDTH-1:0]   r_wb_addr;

  logic [ADDR_WIDTH-1:0]   w_first_addr;
  logic [ADDR_WIDTH-1:0]   w_wb_addr;
  logic                    w_wb_en;
  logic [ADDR_WIDTH-1:0]   w_next_addr;
  logic [BEATS_W-1:0]      w_n;
  logic [BEAT_IDX_W-1:0]   w_last_idx;
  logic                    w_fire;
  logic                    w_accept;

  mem_addr_calc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SRC    (NUM_SRC),
    .SEL_W      (SEL_W)
  ) u_calc (
    .i_src_addr   (src_addr),
    .i_src_sel    (src_sel),
    .i_offset     (offset),
    .i_mode       (mode),
    .o_first_addr (w_first_addr),
    .o_wb_addr    (w_wb_addr),
    .o_wb_en      (w_wb_en)
  );

  // Zero beats means one; anything past MAX_BEATS is clamped.
  assign w_n = (beats == '0) ? BEATS_W'(1) :
               (beats > BEATS_W'(MAX_BEATS)) ? BEATS_W'(MAX_BEATS) : beats;
  assign w_last_idx  = BEAT_IDX_W'(w_n - BEATS_W'(1));
  assign w_next_addr = r_out_addr + ADDR_WIDTH'(WORD_BYTES);
  assign w_fire      = r_out_valid && out_ready;

  // The last-beat handshake counts as idle so a following command issues with no bubble.
  assign in_ready = (!r_out_valid || out_ready) && ((r_state == IDLE) || r_out_last);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_out_beat  <= '0;
      r_last_idx  <= '0;
      r_out_last  <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_addr   <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      if (w_accept) begin
        r_state     <= ISSUE;
        r_out_valid <= 1'b1;
        r_out_addr  <= w_first_addr;
        r_out_beat  <= '0;
        r_last_idx  <= w_last_idx;
        r_out_last  <= (w_last_idx == '0);
        r_wb_valid  <= w_wb_en;
        if (w_wb_en) r_wb_addr <= w_wb_addr;
      end else if (w_fire) begin
        if (r_out_last) begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end else begin
          r_out_addr <= w_next_addr;
          r_out_beat <= r_out_beat + BEAT_IDX_W'(1);
          r_out_last <= ((r_out_beat + BEAT_IDX_W'(1)) == r_last_idx);
        end
      end
    end
  end

`ifdef MEM_ADDR_ALIGN_CHECK_EN
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(WORD_BYTES - 1);
  logic r_misaligned;

  // Flag tracks the address loaded into the output register on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_misaligned <= 1'b0;
    end else if (w_accept) begin
      r_misaligned <= ((w_first_addr & ALIGN_MASK) != '0);
    end else if (w_fire) begin
      r_misaligned <= r_out_last ? 1'b0 : ((w_next_addr & ALIGN_MASK) != '0);
    end
  end
  assign out_misaligned = r_misaligned;
`else
  assign out_misaligned = 1'b0;
`endif

  assign out_valid = r_out_valid;
  assign out_addr  = r_out_addr;
  assign out_beat  = r_out_beat;
  assign out_last  = r_out_last;
  assign wb_valid  = r_wb_valid;
  assign wb_addr   = r_wb_addr;

endmodule

// File: tb/tb_mem_addr_seq_mux.sv
// Directed bench for mem_addr_seq_mux with hand-computed expected values.
// Latency: checks sampled on negedge, one cycle after each driven posedge.
// Backpressure: out_ready toggled explicitly in the backpressure step.
`timescale 1ns/1ps
module tb_mem_addr_seq_mux;

  localparam int AW = 32;
  localparam int NS = 4;
  localparam int MB = 8;
  localparam int WB = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [NS*AW-1:0] src_addr;
  logic [1:0]      src_sel;
  logic [AW-1:0]   offset;
  logic [1:0]      mode;
  logic [3:0]      beats;
  logic            out_valid;
  logic            out_ready;
  logic [AW-1:0]   out_addr;
  logic            out_last;
  logic [2:0]      out_beat;
  logic            wb_valid;
  logic [AW-1:0]   wb_addr;
  logic            out_misaligned;

  int n_chk  = 0;
  int n_fail = 0;

  mem_addr_seq_mux #(
    .ADDR_WIDTH (AW),
    .NUM_SRC    (NS),
    .MAX_BEATS  (MB),
    .WORD_BYTES (WB)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .src_addr       (src_addr),
    .src_sel        (src_sel),
    .offset         (offset),
    .mode           (mode),
    .beats          (beats),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_addr       (out_addr),
    .out_last       (out_last),
    .out_beat       (out_beat),
    .wb_valid       (wb_valid),
    .wb_addr        (wb_addr),
    .out_misaligned (out_misaligned)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [1:0] sel, input logic [AW-1:0] ofs,
                     input logic [1:0] md, input logic [3:0] nb);
    src_sel  = sel;
    offset   = ofs;
    mode     = md;
    beats    = nb;
    in_valid = 1'b1;
  endtask

  // Check one presented beat: valid, address, index, last flag.
  task automatic chk_beat(input string tag, input logic [AW-1:0] a,
                          input logic [2:0] b, input logic l);
    chk({tag, "_valid"}, 64'(out_valid), 64'(1'b1));
    chk({tag, "_addr"},  64'(out_addr),  64'(a));
    chk({tag, "_beat"},  64'(out_beat),  64'(b));
    chk({tag, "_last"},  64'(out_last),  64'(l));
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    src_sel   = '0;
    offset    = '0;
    mode      = '0;
    beats     = '0;
    // src3..src0
    src_addr  = {32'h0000_1002, 32'h0000_1000, 32'h0000_0004, 32'h0000_2000};

    // ---- reset state ----
    repeat (2) @(negedge clock);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_addr",  64'(out_addr),  64'd0);
    chk("rst_out_beat",  64'(out_beat),  64'd0);
    chk("rst_out_last",  64'(out_last),  64'd0);
    chk("rst_wb_valid",  64'(wb_valid),  64'd0);
    chk("rst_wb_addr",   64'(wb_addr),   64'd0);
    chk("rst_misal",     64'(out_misaligned), 64'd0);
    reset = 1'b1;

    // ---- BASE_OFS, src2=0x1000 + 0x10, single beat ----
    @(negedge clock);
    cmd(2'd2, 32'h10, 2'b00, 4'd1);
    #1 chk("t1_in_ready", 64'(in_ready), 64'd1);
    @(negedge clock);
    in_valid = 1'b0;
    chk_beat("t1", 32'h1010, 3'd0, 1'b1);
    chk("t1_wb_valid", 64'(wb_valid), 64'd0);
    @(negedge clock);
    chk("t1_drain", 64'(out_valid), 64'd0);

    // ---- POST_INC, src0=0x2000, ofs 0x20, 4 beats ----
    cmd(2'd0, 32'h20, 2'b01, 4'd4);
    @(negedge clock);
    in_valid = 1'b0;
    chk_beat("t2_b0", 32'h2000, 3'd0, 1'b0);
    chk("t2_wb_valid0", 64'(wb_valid), 64'd1);
    chk("t2_wb_addr",   64'(wb_addr),  64'h2020);
    @(negedge clock);
    chk_beat("t2_b1", 32'h2004, 3'd1, 1'b0);
    chk("t2_wb_valid1", 64'(wb_valid), 64'd0);
    chk("t2_wb_hold",   64'(wb_addr),  64'h2020);
    @(negedge clock);
    chk_beat("t2_b2", 32'h2008, 3'd2, 1'b0);
    @(negedge clock);
    chk_beat("t2_b3", 32'h200C, 3'd3, 1'b1);
    @(negedge clock);
    chk("t2_drain", 64'(out_valid), 64'd0);

    // ---- PRE_DEC, src1=0x4, ofs 8, 3 beats: wraps through zero ----
    cmd(2'd1, 32'h8, 2'b10, 4'd3);
    @(negedge clock);
    in_valid = 1'b0;
    chk_beat("t3_b0", 32'hFFFF_FFFC, 3'd0, 1'b0);
    chk("t3_wb_valid", 64'(wb_valid), 64'd1);
    chk("t3_wb_addr",  64'(wb_addr),  64'hFFFF_FFFC);
    @(negedge clock);
    chk_beat("t3_b1", 32'h0000_0000, 3'd1, 1'b0);
    @(negedge clock);
    chk_beat("t3_b2", 32'h0000_0004, 3'd2, 1'b1);
    @(negedge clock);
    chk("t3_drain", 64'(out_valid), 64'd0);

    // ---- backpressure on beat 1 of 3, back-to-back accept on last beat ----
    cmd(2'd2, 32'h0, 2'b00, 4'd3);
    @(negedge clock);
    in_valid = 1'b0;
    chk_beat("t4_b0", 32'h1000, 3'd0, 1'b0);
    @(negedge clock);
    chk_beat("t4_b1", 32'h1004, 3'd1, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;   // second command waiting throughout the stall
    src_sel   = 2'd2;
    offset    = 32'h40;
    mode      = 2'b00;
    beats     = 4'd0;
    #1 chk("t4_in_ready_stall0", 64'(in_ready), 64'd0);
    @(negedge clock);
    chk_beat("t4_hold1", 32'h1004, 3'd1, 1'b0);
    chk("t4_in_ready_stall1", 64'(in_ready), 64'd0);
    @(negedge clock);
    chk_beat("t4_hold2", 32'h1004, 3'd1, 1'b0);
    out_ready = 1'b1;
    #1 chk("t4_in_ready_b1", 64'(in_ready), 64'd0);
    @(negedge clock);
    chk_beat("t4_b2", 32'h1008, 3'd2, 1'b1);
    chk("t4_in_ready_last", 64'(in_ready), 64'd1);
    @(negedge clock);
    in_valid = 1'b0;
    chk_beat("t4_next", 32'h1040, 3'd0, 1'b1);   // beats=0 -> single beat
    @(negedge clock);
    chk("t4_drain", 64'(out_valid), 64'd0);

    // ---- beats=15 clamped to 8 ----
    cmd(2'd2, 32'h0, 2'b00, 4'd15);
    @(negedge clock);
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_beat($sformatf("t5_b%0d", i), 32'h1000 + 32'(4 * i), 3'(i), (i == 7));
      @(negedge clock);
    end
    chk("t5_drain", 64'(out_valid), 64'd0);

    // ---- reserved mode behaves as BASE_OFS without writeback ----
    cmd(2'd2, 32'h10, 2'b11, 4'd1);
    @(negedge clock);
    in_valid = 1'b0;
    chk_beat("t6", 32'h1010, 3'd0, 1'b1);
    chk("t6_wb_valid", 64'(wb_valid), 64'd0);
    chk("t6_wb_addr",  64'(wb_addr),  64'hFFFF_FFFC);
    @(negedge clock);

    // ---- reset during beat 2 of 4 ----
    cmd(2'd0, 32'h20, 2'b01, 4'd4);
    @(negedge clock);
    in_valid = 1'b0;
    chk_beat("t7_b0", 32'h2000, 3'd0, 1'b0);
    @(negedge clock);
    chk_beat("t7_b1", 32'h2004, 3'd1, 1'b0);
    @(negedge clock);
    chk_beat("t7_b2", 32'h2008, 3'd2, 1'b0);
    reset = 1'b0;
    #1;
    chk("t7_rst_valid", 64'(out_valid), 64'd0);
    chk("t7_rst_addr",  64'(out_addr),  64'd0);
    chk("t7_rst_beat",  64'(out_beat),  64'd0);
    chk("t7_rst_wb",    64'(wb_addr),   64'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk($sformatf("t7_quiet%0d", i), 64'({out_valid, wb_valid}), 64'd0);
    end

    // ---- misaligned base src3=0x1002 ----
    cmd(2'd3, 32'h0, 2'b00, 4'd2);
    @(negedge clock);
    in_valid = 1'b0;
    chk_beat("t8_b0", 32'h1002, 3'd0, 1'b0);
`ifdef MEM_ADDR_ALIGN_CHECK_EN
    chk("t8_misal0", 64'(out_misaligned), 64'd1);
`else
    chk("t8_misal0", 64'(out_misaligned), 64'd0);
`endif
    @(negedge clock);
    chk_beat("t8_b1", 32'h1006, 3'd1, 1'b1);
`ifdef MEM_ADDR_ALIGN_CHECK_EN
    chk("t8_misal1", 64'(out_misaligned), 64'd1);
`else
    chk("t8_misal1", 64'(out_misaligned), 64'd0);
`endif
    @(negedge clock);
    chk("t8_drain", 64'({out_valid, out_misaligned}), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
